// File: rtl/gearbox_pkg.sv
// Shared widths and counter type for the 128<->132 gearboxes.
// Constants only: no logic, no latency, no flow control.
package gearbox_pkg;
    localparam int IN_W        = 128;
    localparam int OUT_W       = 132;
    localparam int NIB_W       = 4;
    localparam int RES_NIB_MAX = 32;
    localparam int PERIOD_IN   = 33;
    localparam int NIB_CNT_W   = 6;

    typedef logic [NIB_CNT_W-1:0] nib_cnt_t;
endpackage

// File: rtl/gearbox_128_132_merge.sv
// Combinational splice of a new 128-bit word onto the residual nibbles.
// Zero latency; no flow control, the caller decides when results are used.
module gearbox_128_132_merge
    import gearbox_pkg::*;
(
    input  logic [IN_W-1:0]      din_i,
    input  logic [IN_W-1:0]      res_i,
    input  logic [NIB_CNT_W-1:0] res_nib_i,
    output logic [OUT_W-1:0]     dout_o,
    output logic [IN_W-1:0]      res_o,
    output logic [NIB_CNT_W-1:0] res_nib_o
);
    logic [7:0]            shamt;
    logic [IN_W+OUT_W-1:0] wide;

    always_comb begin
        shamt = {res_nib_i, 2'b00};
        // Residual bits sit below the shifted word; whatever spills past
        // bit OUT_W-1 is the new residual.
        wide  = ({{OUT_W{1'b0}}, din_i} << shamt) | {{OUT_W{1'b0}}, res_i};
        if (res_nib_i == '0) begin
            dout_o    = '0;
            res_o     = din_i;
            res_nib_o = NIB_CNT_W'(RES_NIB_MAX);
        end else begin
            dout_o    = wide[OUT_W-1:0];
            res_o     = wide[OUT_W +: IN_W];
            res_nib_o = res_nib_i - NIB_CNT_W'(1);
        end
    end
endmodule

// File: rtl/gearbox_128_132.sv
// 128->132 bit width converter: 33 input words become 32 output blocks.
// Output registered, data visible the cycle after the completing input accept.
// din_ready = !dout_valid || dout_ready; output held stable while stalled.
module gearbox_128_132
    import gearbox_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    input  logic [IN_W-1:0]   din,
    output logic              din_ready,
    input  logic              dout_ready,
    output logic              dout_valid,
    output logic [OUT_W-1:0]  dout
);
    logic [OUT_W-1:0]     dout_q, dout_d;
    logic                 dout_valid_q, dout_valid_d;
    logic [IN_W-1:0]      res_q, res_d;
    nib_cnt_t             res_nib_q, res_nib_d;

    logic [OUT_W-1:0]     mrg_dout;
    logic [IN_W-1:0]      mrg_res;
    logic [NIB_CNT_W-1:0] mrg_res_nib;
    logic                 in_xfer;
    logic                 out_xfer;

    gearbox_128_132_merge u_merge (
        .din_i     (din),
        .res_i     (res_q),
        .res_nib_i (res_nib_q),
        .dout_o    (mrg_dout),
        .res_o     (mrg_res),
        .res_nib_o (mrg_res_nib)
    );

    assign din_ready  = !dout_valid_q || dout_ready;
    assign in_xfer    = din_valid && din_ready;
    assign out_xfer   = dout_valid_q && dout_ready;
    assign dout_valid = dout_valid_q;
    assign dout       = dout_q;

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        res_d        = res_q;
        res_nib_d    = res_nib_q;
        if (in_xfer) begin
            res_d     = mrg_res;
            res_nib_d = mrg_res_nib;
            // An empty residual only primes the buffer: this is the bubble slot.
            if (res_nib_q == '0) begin
                dout_valid_d = 1'b0;
            end else begin
                dout_d       = mrg_dout;
                dout_valid_d = 1'b1;
            end
        end else if (out_xfer) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            res_q        <= '0;
            res_nib_q    <= '0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            res_q        <= res_d;
            res_nib_q    <= res_nib_d;
        end
    end
endmodule

// File: tb/tb_gearbox_128_132.sv
// Directed and random checks of gearbox_128_132 against a bitstream scoreboard.
module tb_gearbox_128_132;
    import gearbox_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         din_valid;
    logic [127:0] din;
    logic         din_ready;
    logic         dout_ready;
    logic         dout_valid;
    logic [131:0] dout;

    always #5 clk = ~clk;

    gearbox_128_132 u_dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din        (din),
        .din_ready  (din_ready),
        .dout_ready (dout_ready),
        .dout_valid (dout_valid),
        .dout       (dout)
    );

    typedef struct {
        int           idx;
        logic [131:0] exp;
    } vec_t;

    int           n_chk = 0;
    int           n_pass = 0;
    logic [127:0] W [0:69];
    vec_t         tbl [0:7];
    logic [511:0] acc;
    int           acc_n;
    int           in_cnt;
    logic [131:0] outs [$];

    task automatic chk(input string nm, input logic [131:0] got, input logic [131:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, got, exp);
    endtask

    // Scoreboard: input bits appended in order, each output must be the next 132 bits.
    always @(negedge clk) begin
        if (rst) begin
            acc    = '0;
            acc_n  = 0;
            in_cnt = 0;
            outs.delete();
        end else begin
            if (dout_valid && dout_ready) begin
                outs.push_back(dout);
                if (acc_n < 132) begin
                    n_chk++;
                    $display("FAIL stream_extra: output %h with only %0d bits pending", dout, acc_n);
                end else begin
                    chk("stream", dout, acc[131:0]);
                    acc   = acc >> 132;
                    acc_n = acc_n - 132;
                end
            end
            if (din_valid && din_ready) begin
                acc    = acc | ({384'b0, din} << acc_n);
                acc_n  = acc_n + 128;
                in_cnt = in_cnt + 1;
            end
        end
    end

    task automatic send(input logic [127:0] w);
        int t;
        t = 0;
        din       = w;
        din_valid = 1'b1;
        @(negedge clk);
        while (!din_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!din_ready) begin
            n_chk++;
            $display("FAIL send_timeout: din_ready stuck at %0b, required 1", din_ready);
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] base;
        int           vld_low_at [$];
        int           rdy_low;
        int           sent;
        int           cyc;
        bit           acc_ok;

        base = 128'h0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
        for (int i = 0; i < 70; i++) begin
            logic [7:0] b;
            b    = 8'(i);
            W[i] = base ^ {16{b}};
        end
        tbl[0] = '{idx: 0,  exp: {W[1][3:0],   W[0]}};
        tbl[1] = '{idx: 1,  exp: {W[2][7:0],   W[1][127:4]}};
        tbl[2] = '{idx: 2,  exp: {W[3][11:0],  W[2][127:8]}};
        tbl[3] = '{idx: 15, exp: {W[16][63:0], W[15][127:60]}};
        tbl[4] = '{idx: 31, exp: {W[32],       W[31][127:124]}};
        tbl[5] = '{idx: 32, exp: {W[34][3:0],  W[33]}};
        tbl[6] = '{idx: 33, exp: {W[35][7:0],  W[34][127:4]}};
        tbl[7] = '{idx: 63, exp: {W[65],       W[64][127:124]}};

        // Reset held with din_valid high must not disturb anything.
        rst        = 1'b1;
        din_valid  = 1'b1;
        din        = W[5];
        dout_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_vld",  132'(dout_valid), 132'(0));
            chk("rst_dout", dout, 132'(0));
            chk("rst_nib",  132'(u_dut.res_nib_q), 132'(0));
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", 132'(din_ready), 132'(1));
        @(posedge clk);
        #1;

        // Two full periods back to back with no stalls.
        rdy_low = 0;
        for (int i = 0; i < 66; i++) begin
            din       = W[i];
            din_valid = 1'b1;
            @(negedge clk);
            if (!din_ready) rdy_low++;
            if (!dout_valid) vld_low_at.push_back(i);
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("cont_rdy_low", 132'(rdy_low), 132'(0));
        chk("cont_n_out", 132'(outs.size()), 132'(64));
        chk("cont_n_bubble", 132'(vld_low_at.size()), 132'(3));
        if (vld_low_at.size() == 3) begin
            chk("bubble0", 132'(vld_low_at[0]), 132'(0));
            chk("bubble1", 132'(vld_low_at[1]), 132'(1));
            chk("bubble2", 132'(vld_low_at[2]), 132'(34));
        end
        for (int t = 0; t < 8; t++) begin
            if (tbl[t].idx < outs.size())
                chk($sformatf("tbl_out%0d", tbl[t].idx), outs[tbl[t].idx], tbl[t].exp);
            else begin
                n_chk++;
                $display("FAIL tbl_out%0d: missing, only %0d outputs", tbl[t].idx, outs.size());
            end
        end

        // Backpressure: stall while out2 is presented.
        do_reset();
        for (int i = 0; i < 4; i++) send(W[i]);
        dout_ready = 1'b0;
        din        = W[4];
        din_valid  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_vld",  132'(dout_valid), 132'(1));
            chk("bp_rdy",  132'(din_ready), 132'(0));
            chk("bp_dout", dout, tbl[2].exp);
        end
        @(posedge clk);
        #1;
        dout_ready = 1'b1;
        for (int i = 4; i < 41; i++) send(W[i]);
        repeat (2) @(negedge clk);
        #1;
        chk("bp_n_out", 132'(outs.size()), 132'(39));

        // Reset at phase 17 discards the partial block.
        do_reset();
        for (int i = 0; i < 16; i++) send(W[i]);
        chk("mid_nib17", 132'(u_dut.res_nib_q), 132'(17));
        din       = W[16];
        din_valid = 1'b1;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        chk("mid_res",  132'(u_dut.res_q), 132'(0));
        chk("mid_nib",  132'(u_dut.res_nib_q), 132'(0));
        chk("mid_vld",  132'(dout_valid), 132'(0));
        chk("mid_dout", dout, 132'(0));
        @(posedge clk);
        #1;
        send(W[0]);
        @(negedge clk);
        chk("mid_first_vld", 132'(dout_valid), 132'(0));
        @(posedge clk);
        #1;
        send(W[1]);
        @(negedge clk);
        chk("mid_second_vld", 132'(dout_valid), 132'(1));
        chk("mid_second_dout", dout, tbl[0].exp);

        // Random valid/ready, 10000 words through the scoreboard.
        do_reset();
        sent      = 0;
        cyc       = 0;
        din_valid = 1'b0;
        while (sent < 10000 && cyc < 80000) begin
            dout_ready = ($urandom_range(0, 3) != 0);
            if (!din_valid && $urandom_range(0, 3) != 0) begin
                din       = {$urandom(), $urandom(), $urandom(), $urandom()};
                din_valid = 1'b1;
            end
            @(negedge clk);
            acc_ok = din_valid && din_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc_ok) begin
                sent++;
                din_valid = 1'b0;
            end
        end
        if (sent < 10000) begin
            n_chk++;
            $display("FAIL rand_timeout: sent %0d words, required 10000", sent);
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rand_in_cnt", 132'(in_cnt), 132'(sent));
        chk("rand_n_out", 132'(outs.size()), 132'((sent * 128) / 132));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/gearbox_128_132.md
# gearbox_128_132

Width converter from a 128-bit word stream to a 132-bit word stream: the transmit-side counterpart of the 132→128 gearbox, rebuilding 132-bit blocks from 128-bit words. Every 33 accepted input words produce exactly 32 output words, because 33×128 = 32×132 = 4224 bits. It sits between a 128-bit datapath source and a 132-bit block consumer. Both sides use valid/ready handshakes, and the output is fully registered.

## Interface
- No parameters. Widths are fixed by package constants.
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- din_valid  in  1  input word valid
- din  in  128  input word; bit 0 is the earliest bit on the line
- din_ready  out  1  block can accept din this cycle
- dout_ready  in  1  downstream accepts dout this cycle
- dout_valid  out  1  dout holds a complete 132-bit block
- dout  out  132  output block; bit 0 is the earliest bit

## Operation
- Input transfer: din_valid && din_ready. Output transfer: dout_valid && dout_ready.
- din_ready = !dout_valid || dout_ready.
  - Purely a function of output-register state; never depends on din_valid.
- Residual buffer res[127:0] with count res_nib (6 bits, range 0..32, in 4-bit nibbles). Bits held = 4·res_nib. The oldest bit is res[0].
- On input transfer with res_nib = 0:
  - res ← din, res_nib ← 32.
  - No output produced (the bubble slot).
- On input transfer with res_nib = k > 0:
  - dout ← ({din,128'b0}… concatenation) low 132 bits of (din << 4k) | res. That is, res low 4k bits, then din low 132−4k bits.
  - res ← din >> (132−4k), zero-filled; res_nib ← k−1; dout_valid ← 1.
- The phase sequence is 0, 32, 31, …, 1, 0 and repeats with period 33 input words. res_nib wraps from 1 to 0 on the 33rd word, never below 0.
- No input transfer and output transfer: dout_valid ← 0. res and res_nib are unchanged.
- No input transfer and no output transfer: all state holds, including dout.
- Input transfer with res_nib = 0 while an output transfer occurs: dout_valid ← 0 and dout is don't-care. The rule is the same when no output transfer occurs, since din_ready guarantees dout_valid is 0 or being consumed.
- Upstream gaps (din_valid low) stall the phase; there is no timeout.

## Timing
- Reset values: dout_valid = 0, dout = 0, res = 0, res_nib = 0. din_ready = 1 in the first cycle after reset.
- Reset mid-stream discards any partial block. The first word after reset is treated as phase 0, i.e. buffered with no output.
- Latency: dout_valid rises on the edge that accepts the completing input word. Data is visible the cycle after that input transfer.
- Throughput with dout_ready held at 1 and continuous din_valid:
  - din_ready stays 1 every cycle.
  - dout_valid is high 32 of every 33 cycles, low in the cycle following each phase-0 accept.
- Backpressure: dout and dout_valid stay stable while dout_valid && !dout_ready. din_ready is 0 in those cycles.

## Structure
- Shared package gearbox_pkg holds:
  - IN_W = 128, OUT_W = 132, NIB_W = 4
  - RES_NIB_MAX = 32, PERIOD_IN = 33
  - The typedef for the 6-bit nibble counter.
  - The 132→128 gearbox uses the same constants.
- One natural sub-module: gearbox_128_132_merge, purely combinational. It takes din, res and res_nib and returns the next dout and next res. The shift/OR network is isolated there and the top level holds the registers and handshake.
- Registers use the team's synchronous-reset flop primitive with an active-high rst.

## Test plan
- Reset: assert rst for 3 cycles with din_valid = 1.
  - Required: dout_valid = 0, dout = 0, no state change.
  - After release: din_ready = 1.
- Continuous stream: send 33 words w0..w32 with w_i = 128'h{i repeated} and dout_ready = 1.
  - Required: 32 outputs.
  - First output: {w1[3:0], w0}.
  - Second output: {w2[7:0], w1[127:4]}.
  - Last output: {w32, w31[127:124]}.
  - One dout_valid bubble, after w0.
- Wrap: send 66 words.
  - Required: 64 outputs.
  - Output 33 is {w34[3:0], w33], i.e. the same pattern as output 1, confirming the period of 33.
- Backpressure: hold dout_ready = 0 for 5 cycles mid-stream.
  - Required: din_ready = 0 throughout, dout stable.
  - After release, outputs resume with no lost or duplicated bits.
- Random din_valid and dout_ready with a 10 000-word scoreboard.
  - Required: the concatenated output bitstream equals the input bitstream.
- Mid-stream reset at phase 17.
  - Required: next-cycle state is all zero.
  - The following first word produces no output; the second word yields {w1[3:0], w0}.
